// File: rtl/nios_mem_copier.sv
// nios_mem_copier
// ----------------
// Copies a block of 32-bit words inside a single on-chip memory, one word at a
// time, as a read / wait / write sequence of exactly three cycles per word.
// A request whose source or destination range runs past the end of the memory
// is rejected (err held high) without touching the memory.
//
// Ports
//   clk, reset_n          single clock, asynchronous active-low reset
//   start                 one-cycle request, honoured only while idle
//   abort                 stop after the word currently in flight
//   src_addr, dst_addr    first source / destination word address (sampled with start)
//   len                   number of words (sampled with start)
//   busy                  high while words are being moved
//   done                  one-cycle pulse at the end of every request
//   err                   high while the last request stands rejected
//   m_*                   memory master port (fixed one-cycle read latency)
//
// All outputs are registered: each output register is loaded from the value
// the next state will present, so outputs line up with the state register.

module nios_mem_copier #(
    parameter int DEPTH = 5320,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] m_address,
    output logic          m_chipselect,
    output logic          m_write,
    output logic [3:0]    m_byteenable,
    output logic [31:0]   m_writedata,
    input  logic [31:0]   m_readdata,
    output logic          m_clken
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Range checks are done one bit wider than the address so they never wrap.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_r, state_s;
    logic [AW-1:0] src_r, src_s;
    logic [AW-1:0] dst_r, dst_s;
    logic [AW-1:0] len_r, len_s;
    logic [AW-1:0] i_r, i_s;
    logic [31:0]   data_r, data_s;
    logic          abort_r, abort_s;
    logic          err_r, err_s;

    logic          busy_r, done_r, cs_r, wr_r;
    logic [AW-1:0] addr_r, addr_s;
    logic [31:0]   wdata_r, wdata_s;

    logic [AW:0]   src_end_s;
    logic [AW:0]   dst_end_s;

    // End-of-range sums for the request presented on the inputs.
    always_comb begin
        src_end_s = {1'b0, src_addr} + {1'b0, len};
        dst_end_s = {1'b0, dst_addr} + {1'b0, len};
    end

    // Next-state and next-value logic for the copy sequencer.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        len_s   = len_r;
        i_s     = i_r;
        data_s  = data_r;
        abort_s = abort_r;
        err_s   = err_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    src_s   = src_addr;
                    dst_s   = dst_addr;
                    len_s   = len;
                    i_s     = {AW{1'b0}};
                    err_s   = 1'b0;
                    abort_s = 1'b0;
                    if (len == {AW{1'b0}}) begin
                        state_s = DONE;
                    end else if ((src_end_s > DEPTH_W) || (dst_end_s > DEPTH_W)) begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                // An abort seen before the write is remembered so this word still lands.
                abort_s = abort_r | abort;
                state_s = WAIT;
            end
            WAIT: begin
                abort_s = abort_r | abort;
                data_s  = m_readdata;
                state_s = WR;
            end
            WR: begin
                i_s = i_r + AW'(1);
                if (((i_r + AW'(1)) == len_r) || abort || abort_r) begin
                    state_s = DONE;
                end else begin
                    state_s = RD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Memory address and write data the next state will present.
    always_comb begin
        addr_s  = {AW{1'b0}};
        wdata_s = wdata_r;
        case (state_s)
            RD: begin
                addr_s = src_s + i_s;
            end
            WR: begin
                addr_s  = dst_s + i_s;
                wdata_s = data_s;
            end
            default: begin
                addr_s = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state and working registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            src_r   <= {AW{1'b0}};
            dst_r   <= {AW{1'b0}};
            len_r   <= {AW{1'b0}};
            i_r     <= {AW{1'b0}};
            data_r  <= 32'h0;
            abort_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            len_r   <= len_s;
            i_r     <= i_s;
            data_r  <= data_s;
            abort_r <= abort_s;
            err_r   <= err_s;
        end
    end

    // Registered outputs, loaded from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cs_r    <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= {AW{1'b0}};
            wdata_r <= 32'h0;
        end else begin
            busy_r  <= (state_s == RD) || (state_s == WAIT) || (state_s == WR);
            done_r  <= (state_s == DONE);
            cs_r    <= (state_s == RD) || (state_s == WR);
            wr_r    <= (state_s == WR);
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign err          = err_r;
    assign m_address    = addr_r;
    assign m_chipselect = cs_r;
    assign m_write      = wr_r;
    assign m_writedata  = wdata_r;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;

endmodule

// File: tb/tb_nios_mem_copier.sv
// Testbench for nios_mem_copier: table of copy requests with hand-computed
// completion cycle, error flag and word count, checked against a behavioural
// memory and a reference copy of it; plus reset-during-copy sequences.

module tb_nios_mem_copier;

    localparam int DEPTH = 5320;
    localparam int AW    = 13;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] m_address;
    logic          m_chipselect;
    logic          m_write;
    logic [3:0]    m_byteenable;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata;
    logic          m_clken;

    nios_mem_copier #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_clken      (m_clken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural on-chip memory with one-cycle read latency.
    logic [31:0] mem [DEPTH];
    logic [31:0] exp_mem [DEPTH];

    always @(posedge clk) begin
        if (m_chipselect && m_write) begin
            mem[m_address] <= m_writedata;
        end
        if (m_chipselect && !m_write) begin
            m_readdata <= mem[m_address];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        string name;
        int    src;
        int    dst;
        int    len;
        int    abort_cyc;   // cycle on whose closing edge abort is seen; 0 = none
        int    restart;     // re-pulse start with other arguments mid-copy
        int    exp_err;
        int    exp_done;    // cycle in which done is high
        int    exp_wr;      // words actually written
    } vec_t;

    vec_t vecs[9];
    vec_t post_vec;

    task automatic run_vec(input vec_t v);
        int done_cyc = 0;
        int done_cnt = 0;
        int nrd      = 0;
        int nwr      = 0;
        int busy_bad = 0;
        int bus_bad  = 0;
        int diffs    = 0;
        int bound;
        bound = 3 * v.len + 8;
        @(negedge clk);
        src_addr = AW'(v.src);
        dst_addr = AW'(v.dst);
        len      = AW'(v.len);
        abort    = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (v.restart != 0 && c == 4) begin
                start    = 1'b1;
                src_addr = AW'(1000);
                dst_addr = AW'(2000);
                len      = AW'(1);
            end
            if (v.restart != 0 && c == 5) start = 1'b0;
            abort = (v.abort_cyc != 0) && (c == v.abort_cyc);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (busy != (c < v.exp_done)) busy_bad++;
            if (m_chipselect && !m_write) nrd++;
            if (m_chipselect && m_write) nwr++;
            if (m_write && !m_chipselect) bus_bad++;
            if (m_byteenable != 4'hF || m_clken != 1'b1) bus_bad++;
            if (done_cyc != 0 && c >= done_cyc + 2) break;
        end
        abort = 1'b0;
        start = 1'b0;
        for (int w = 0; w < v.exp_wr; w++) begin
            exp_mem[v.dst + w] = exp_mem[v.src + w];
        end
        for (int a = 0; a < DEPTH; a++) begin
            if (mem[a] !== exp_mem[a]) diffs++;
        end
        check({v.name, " done_cycle"}, done_cyc, v.exp_done);
        check({v.name, " done_pulses"}, done_cnt, 1);
        check({v.name, " err"}, int'(err), v.exp_err);
        check({v.name, " reads"}, nrd, v.exp_wr);
        check({v.name, " writes"}, nwr, v.exp_wr);
        check({v.name, " busy_window"}, busy_bad, 0);
        check({v.name, " bus_rules"}, bus_bad, 0);
        check({v.name, " mem_diffs"}, diffs, 0);
    endtask

    initial begin
        //          name          src   dst   len abort rst err done wr
        vecs[0] = '{"basic4",       0,  100,   4,   0,  0,  0,  13,  4};
        vecs[1] = '{"len0",         7,    9,   0,   0,  0,  0,   1,  0};
        vecs[2] = '{"src_over",  5318,    0,   3,   0,  0,  1,   1,  0};
        vecs[3] = '{"abort_w2",    10,   50,  10,   8,  0,  0,  10,  3};
        vecs[4] = '{"dst_edge",     0, 5317,   3,   0,  0,  0,  10,  3};
        vecs[5] = '{"dst_over",     0, 5318,   3,   0,  0,  1,   1,  0};
        vecs[6] = '{"overlap",     20,   21,   3,   0,  0,  0,  10,  3};
        vecs[7] = '{"restart",     40,   60,   3,   0,  1,  0,  10,  3};
        vecs[8] = '{"len1",      3000, 3001,   1,   0,  0,  0,   4,  1};
        post_vec = '{"post_rst",  500,  600,   2,   0,  0,  0,   7,  2};

        for (int a = 0; a < DEPTH; a++) begin
            mem[a]     = 32'(a) + 32'hA0;
            exp_mem[a] = 32'(a) + 32'hA0;
        end
        m_readdata = 32'h0;
        start      = 1'b0;
        abort      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        len        = '0;
        reset_n    = 1'b0;
        #1;
        check("reset_outputs",
              int'({busy, done, err, m_chipselect, m_write}) + int'(m_address) + int'(m_writedata), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Abort while idle must not affect the next request.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", int'(busy), 0);

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k]);
        end

        // Reset during word 1's WAIT (cycle 5): word 0 landed, word 1 must not.
        @(negedge clk);
        src_addr = AW'(0);
        dst_addr = AW'(300);
        len      = AW'(4);
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_async_outputs",
              int'({busy, done, err, m_chipselect, m_write}) + int'(m_address) + int'(m_writedata), 0);
        repeat (2) @(negedge clk);
        check("reset_held_cs", int'(m_chipselect), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_word0_written", int'(mem[300]), 32'hA0);
        check("reset_word1_not_written", int'(mem[301]), 301 + 32'hA0);
        check("reset_word2_not_written", int'(mem[302]), 302 + 32'hA0);
        exp_mem[300] = exp_mem[0];

        run_vec(post_vec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a stuck design still reaches the summary.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
